// File: rtl/resource_lock_arbiter.sv
// Age-ordered lock arbiter: hands NUM_UNITS shared execution units to the oldest pending requesters.
// Optional watchdog force-free of long-held locks is enabled by defining LOCK_TIMEOUT_EN.
module resource_lock_arbiter #(
    parameter int NUM_PORTS      = 8,
    parameter int NUM_UNITS      = 1,
    parameter int ID_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int UNIT_W        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int PORT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
    // "release" is a reserved word, hence the longer name
    input  logic [NUM_PORTS-1:0]          lock_release,
    input  logic                          flush,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [NUM_PORTS*UNIT_W-1:0]   grant_unit,
    output logic [NUM_UNITS-1:0]          unit_busy,
    output logic [NUM_UNITS*PORT_W-1:0]   unit_owner,
    output logic [NUM_UNITS-1:0]          timeout_evt
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } unit_state_t;

    unit_state_t       state_q [NUM_UNITS];
    unit_state_t       state_d [NUM_UNITS];
    logic [PORT_W-1:0] owner_q [NUM_UNITS];
    logic [PORT_W-1:0] owner_d [NUM_UNITS];
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_UNITS-1:0] expired;
    int                   rank [NUM_PORTS];

    // Wrap-safe age compare; equal IDs resolve to the lower port index.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] id_a,
                                      input logic [ID_WIDTH-1:0] id_b,
                                      input int port_a,
                                      input int port_b);
        logic [ID_WIDTH-1:0] diff;
        diff = id_a - id_b;
        return diff[ID_WIDTH-1] || ((diff == '0) && (port_a < port_b));
    endfunction

    // All outputs are decoded from the per-unit lock registers only.
    always_comb begin
        grant      = '0;
        grant_unit = '0;
        unit_busy  = '0;
        unit_owner = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (state_q[u] == LOCKED) begin
                unit_busy[u]                          = 1'b1;
                unit_owner[u*PORT_W +: PORT_W]        = owner_q[u];
                grant[owner_q[u]]                     = 1'b1;
                grant_unit[owner_q[u]*UNIT_W +: UNIT_W] = UNIT_W'(u);
            end
        end
    end

    // rank[p] = number of pending ports older than p, giving a strict total order.
    always_comb begin
        pending = req_valid & ~grant & ~lock_release;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rank[p] = 0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if ((q != p) && pending[q] &&
                    is_older(req_id[q*ID_WIDTH +: ID_WIDTH], req_id[p*ID_WIDTH +: ID_WIDTH], q, p)) begin
                    rank[p] = rank[p] + 1;
                end
            end
        end
    end

    // The k-th idle unit (ascending index) locks to the pending port of rank k.
    always_comb begin
        int idle_seen;
        idle_seen = 0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            state_d[u] = state_q[u];
            owner_d[u] = owner_q[u];
            if (state_q[u] == LOCKED) begin
                if (flush || expired[u] || lock_release[owner_q[u]] || !req_valid[owner_q[u]]) begin
                    state_d[u] = IDLE;
                    owner_d[u] = '0;
                end
            end else begin
                if (!flush) begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (pending[p] && (rank[p] == idle_seen)) begin
                            state_d[u] = LOCKED;
                            owner_d[u] = PORT_W'(p);
                        end
                    end
                end
                idle_seen = idle_seen + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_q[u] <= IDLE;
                owner_q[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_q[u] <= state_d[u];
                owner_q[u] <= owner_d[u];
            end
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] hold_cnt [NUM_UNITS];

    // Held at zero while idle so the first locked cycle counts from 0; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                hold_cnt[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (state_q[u] == IDLE) begin
                    hold_cnt[u] <= '0;
                end else if (hold_cnt[u] != CNT_W'(TIMEOUT_CYCLES)) begin
                    hold_cnt[u] <= hold_cnt[u] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            expired[u] = (state_q[u] == LOCKED) && (hold_cnt[u] == CNT_W'(TIMEOUT_CYCLES));
        end
    end

    assign timeout_evt = expired;
`else
    assign expired     = '0;
    assign timeout_evt = '0;
`endif

endmodule

// File: tb/tb_resource_lock_arbiter.sv
// Directed scoreboard bench for resource_lock_arbiter (4 ports, 2 units); checks the
// watchdog path when LOCK_TIMEOUT_EN is defined and indefinite holding otherwise.
module tb_resource_lock_arbiter;

    localparam int P  = 4;
    localparam int U  = 2;
    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [P-1:0]   req_valid;
    logic [P*W-1:0] req_id;
    logic [P-1:0]   lock_release;
    logic           flush;
    logic [P-1:0]   grant;
    logic [P-1:0]   grant_unit;
    logic [U-1:0]   unit_busy;
    logic [U*2-1:0] unit_owner;
    logic [U-1:0]   timeout_evt;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] gu;
        logic [1:0] b;
        logic [3:0] own;
        logic [1:0] t;
    } snap_t;

    int    exp_cyc  [$];
    string exp_name [$];
    snap_t exp_val  [$];

    int cyc    = 0;
    int base   = 0;
    int end_r  = 0;
    int tests  = 0;
    int errors = 0;

    resource_lock_arbiter #(
        .NUM_PORTS(P), .NUM_UNITS(U), .ID_WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
        .lock_release(lock_release), .flush(flush), .grant(grant),
        .grant_unit(grant_unit), .unit_busy(unit_busy), .unit_owner(unit_owner),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t apply_mask(input snap_t s, input snap_t m);
        snap_t r;
        r = s;
        for (int p = 0; p < P; p++) if (!m.g[p]) r.gu[p] = 1'b0;
        for (int u = 0; u < U; u++) if (!m.b[u]) r.own[u*2 +: 2] = 2'b00;
        return r;
    endfunction

    task automatic checkOutput(input string name, input snap_t act, input snap_t exp);
        snap_t a, e;
        a = apply_mask(act, exp);
        e = apply_mask(exp, exp);
        tests++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s @%0d: got g=%b gu=%b busy=%b own=%b tevt=%b, expected g=%b gu=%b busy=%b own=%b tevt=%b",
                     name, cyc, a.g, a.gu, a.b, a.own, a.t, e.g, e.gu, e.b, e.own, e.t);
        end
    endtask

    // Monitor: compares the DUT outputs whenever a scheduled expectation falls due.
    always @(negedge clk) begin
        snap_t act;
        if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
            act = {grant, grant_unit, unit_busy, unit_owner, timeout_evt};
            void'(exp_cyc.pop_front());
            checkOutput(exp_name.pop_front(), act, exp_val.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_rel(input int r);
        while (cyc < base + r) step();
    endtask

    task automatic push(input int abs_cyc, input string name, input logic [3:0] g,
                        input logic [3:0] gu, input logic [1:0] b, input logic [3:0] own,
                        input logic [1:0] t);
        exp_cyc.push_back(abs_cyc);
        exp_name.push_back(name);
        exp_val.push_back({g, gu, b, own, t});
    endtask

    task automatic set_id(input int p, input logic [W-1:0] v);
        req_id[p*W +: W] = v;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] rel, input logic fl);
        req_valid    = valid;
        lock_release = rel;
        flush        = fl;
    endtask

    initial begin
        reset = 1'b1;
        req_id = '0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        repeat (3) step();
        push(cyc, "reset", 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00);

        reset = 1'b0;
        base  = cyc;
        set_id(0, 16'd10); set_id(1, 16'd5); set_id(2, 16'd7); set_id(3, 16'd12);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        push(base + 1, "alloc",    4'b0110, 4'b0100, 2'b11, 4'b1001, 2'b00);
        push(base + 2, "hold",     4'b0110, 4'b0100, 2'b11, 4'b1001, 2'b00);
        push(base + 3, "hold_rel", 4'b0110, 4'b0100, 2'b11, 4'b1001, 2'b00);

        at_rel(3);
        applyStimulus(4'b1101, 4'b0010, 1'b0);
        push(base + 4, "release", 4'b0100, 4'b0100, 2'b10, 4'b1000, 2'b00);

        at_rel(4);
        applyStimulus(4'b1101, 4'b0000, 1'b0);
        push(base + 5, "refill", 4'b0101, 4'b0100, 2'b11, 4'b1000, 2'b00);

        at_rel(5);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        push(base + 6, "implicit", 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);

        at_rel(6);
        set_id(1, 16'd20); set_id(2, 16'd20);
        applyStimulus(4'b0111, 4'b0000, 1'b0);
        push(base + 7, "tie", 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b00);

        at_rel(7);
        applyStimulus(4'b0111, 4'b0010, 1'b0);
        push(base + 8, "rel_req", 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);

        at_rel(8);
        applyStimulus(4'b0111, 4'b0000, 1'b0);
        push(base + 9, "regrant", 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b00);

        at_rel(9);
        applyStimulus(4'b0111, 4'b1100, 1'b0);
        push(base + 10, "bad_rel", 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b00);

        at_rel(10);
        set_id(3, 16'd15);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        push(base + 11, "pre_flush", 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b00);

        at_rel(11);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        push(base + 12, "flush", 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00);

        at_rel(12);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        push(base + 13, "post_flush", 4'b1001, 4'b1000, 2'b11, 4'b1100, 2'b00);

        at_rel(13);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        push(base + 14, "drop", 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);

        at_rel(14);
        set_id(1, 16'h0003); set_id(2, 16'hFFFE);
        applyStimulus(4'b0111, 4'b0000, 1'b0);
        push(base + 15, "wrap", 4'b0101, 4'b0100, 2'b11, 4'b1000, 2'b00);

        at_rel(15);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        push(base + 16, "alone", 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);

`ifdef LOCK_TIMEOUT_EN
        // Port 0 relocked at R13, so its hold count reaches TO at R13+TO.
        push(base + 12 + TO, "pre_timeout", 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);
        push(base + 13 + TO, "timeout",     4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b01);
        push(base + 14 + TO, "forced_free", 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00);
        push(base + 15 + TO, "relock",      4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);
        end_r = 16 + TO;
`else
        push(base + 50,  "hold_50",  4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);
        push(base + 116, "hold_116", 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b00);
        end_r = 117;
`endif

        at_rel(end_r);
        reset = 1'b1;
        push(base + end_r + 1, "reset_mid", 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00);

        for (int i = 0; i < 10 && exp_cyc.size() > 0; i++) step();
        if (exp_cyc.size() > 0) begin
            $display("[TB] FAIL unchecked: %0d expectations never reached, required 0", exp_cyc.size());
            tests  += exp_cyc.size();
            errors += exp_cyc.size();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
